// File: rtl/loader_pkg.sv
// loader_pkg
// Shared definitions for the program loader and its instruction RAM:
// the loader state encoding, the instruction memory size in bytes and
// the byte granularity used by both the load stream and the storage.
package loader_pkg;

    localparam int MEM_BYTES  = 256;
    localparam int BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/instr_ram.sv
// instr_ram
// Byte-addressed instruction memory with one synchronous byte write port
// and one combinational little-endian multi-byte read port.
//
// Ports:
//   clk    - write clock
//   we     - byte write enable
//   waddr  - byte write address
//   wdata  - byte to write
//   raddr  - byte read address of the lowest byte of the word
//   rdata  - {mem[raddr+N-1], ..., mem[raddr+1], mem[raddr]}
module instr_ram #(
    parameter int MEM_ADDR_BITS = 8,
    parameter int BYTE_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [MEM_ADDR_BITS-1:0] waddr,
    input  logic [BYTE_WIDTH-1:0]    wdata,
    input  logic [MEM_ADDR_BITS-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);
    import loader_pkg::*;

    localparam int DEPTH = 1 << MEM_ADDR_BITS;
    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

    logic [BYTE_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately never cleared, so a reset mid-load keeps
    // whatever bytes have already been written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Each lane index is computed at the RAM address width, so a word read
    // near the top of memory wraps around to address 0.
    always_comb begin
        rdata = '0;
        for (int lane = 0; lane < LANES; lane++) begin
            rdata[lane*BYTE_WIDTH +: BYTE_WIDTH] = mem[raddr + MEM_ADDR_BITS'(lane)];
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader
// Writer side of the instruction memory. Accepts a program as a byte
// stream over a valid/ready handshake, stores it little-endian from
// address 0 and holds the CPU in reset until the load has completed.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   start     - request to begin a (re)load, honoured in IDLE and DONE
//   length    - byte count of the load, sampled with start, clamped to RAM size
//   in_valid  - in_byte carries a program byte
//   in_byte   - program byte, ascending address order
//   in_ready  - loader takes a byte this cycle (registered)
//   busy      - load in progress
//   done      - last load completed, held until next start or rst
//   cpu_rst   - core reset request, low only in DONE
//   addr      - fetch byte address, low MEM_ADDR_BITS decoded
//   instr     - combinational little-endian fetch word
module prog_loader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 8,
    parameter int BYTE_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [MEM_ADDR_BITS:0]   length,
    input  logic                     in_valid,
    input  logic [BYTE_WIDTH-1:0]    in_byte,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     cpu_rst,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0]    instr
);
    import loader_pkg::*;

    localparam logic [MEM_ADDR_BITS:0] MAX_LEN = {1'b1, {MEM_ADDR_BITS{1'b0}}};

    loader_state_t            state;
    logic [MEM_ADDR_BITS-1:0] wr_ptr;
    logic [MEM_ADDR_BITS:0]   len_latch;
    logic [MEM_ADDR_BITS:0]   start_len;
    logic [MEM_ADDR_BITS:0]   accepted_after;
    logic                     we;
    logic                     unused_addr;

    assign start_len      = (length > MAX_LEN) ? MAX_LEN : length;
    assign accepted_after = {1'b0, wr_ptr} + {{MEM_ADDR_BITS{1'b0}}, 1'b1};

    // in_ready is a register, so the handshake has no combinational path
    // from in_valid; rst blocks a write in the same cycle it is asserted.
    assign we = in_valid && in_ready && !rst;

    assign unused_addr = ^addr[ADDRESS_WIDTH-1:MEM_ADDR_BITS];

    // Load sequencer. The byte count is compared one bit wider than the
    // pointer so a full 256-byte load terminates; the pointer rolling over
    // to 0 on that final byte is harmless because the load is finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            len_latch <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_rst   <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len_latch <= start_len;
                        wr_ptr    <= '0;
                        if (start_len == '0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_rst  <= 1'b0;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            cpu_rst  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        wr_ptr <= wr_ptr + MEM_ADDR_BITS'(1);
                        if (accepted_after == len_latch) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_rst  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    cpu_rst  <= 1'b1;
                end
            endcase
        end
    end

    instr_ram #(
        .MEM_ADDR_BITS (MEM_ADDR_BITS),
        .BYTE_WIDTH    (BYTE_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_instr_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (in_byte),
        .raddr (addr[MEM_ADDR_BITS-1:0]),
        .rdata (instr)
    );

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Self-checking bench for prog_loader. A byte-array model of the RAM is
// updated from the load rules (clamped length, bytes stored in ascending
// order from address 0) and fetch words are rebuilt from it.
module tb_prog_loader;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAB = 8;
    localparam int BW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [MAB:0]   length;
    logic           in_valid;
    logic [BW-1:0]  in_byte;
    logic           in_ready;
    logic           busy;
    logic           done;
    logic           cpu_rst;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  instr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] stream  [512];
    logic [7:0] ref_mem [256];
    bit         ref_known [256];

    prog_loader #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .MEM_ADDR_BITS (MAB),
        .BYTE_WIDTH    (BW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .length   (length),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .cpu_rst  (cpu_rst),
        .addr     (addr),
        .instr    (instr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_word(input int a);
        return {ref_mem[(a + 3) % 256], ref_mem[(a + 2) % 256],
                ref_mem[(a + 1) % 256], ref_mem[a % 256]};
    endfunction

    function automatic bit word_known(input int a);
        return ref_known[a % 256] && ref_known[(a + 1) % 256] &&
               ref_known[(a + 2) % 256] && ref_known[(a + 3) % 256];
    endfunction

    // Starts a load and streams stream[0..] until the clamped length has
    // been offered with valid. mode 0: continuous, 1: valid pattern
    // 1,0,0,1 repeating, 2: random valid.
    task automatic run_load(input int len_req, input int mode, input bit hold_start);
        int exp_len;
        int acc;
        int cyc;
        bit v;
        bit exp_done;
        exp_len  = (len_req > 256) ? 256 : len_req;
        acc      = 0;
        cyc      = 0;
        in_valid = 1'b0;
        start    = 1'b1;
        length   = 9'(len_req);
        tick();
        start  = hold_start;
        length = 9'($urandom_range(0, 511));
        n_cmp++;
        if ({in_ready, busy, done, cpu_rst} !== 4'b1101) begin
            n_bad++;
            $display("[TB] FAIL load_entry {rdy,busy,done,cpu_rst} actual=%b required=1101",
                     {in_ready, busy, done, cpu_rst});
        end
        while (acc < exp_len && cyc < 4000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_byte  = v ? stream[acc] : 8'($urandom());
            addr     = ($urandom() & 32'hFFFF_FF00) | 32'(acc);
            #1;
            if (ref_known[acc]) begin
                n_cmp++;
                if (instr[7:0] !== ref_mem[acc]) begin
                    n_bad++;
                    $display("[TB] FAIL same_cycle_old addr=%02h actual=%02h required=%02h",
                             acc, instr[7:0], ref_mem[acc]);
                end
            end
            tick();
            cyc++;
            if (v) begin
                n_cmp++;
                if (instr[7:0] !== stream[acc]) begin
                    n_bad++;
                    $display("[TB] FAIL write_visible addr=%02h actual=%02h required=%02h",
                             acc, instr[7:0], stream[acc]);
                end
                acc++;
            end
            exp_done = (acc == exp_len);
            n_cmp++;
            if ({in_ready, busy, done, cpu_rst} !== (exp_done ? 4'b0010 : 4'b1101)) begin
                n_bad++;
                $display("[TB] FAIL load_status after %0d bytes actual=%b required=%b",
                         acc, {in_ready, busy, done, cpu_rst}, exp_done ? 4'b0010 : 4'b1101);
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (acc < exp_len) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL load_timeout actual=%0d bytes required=%0d", acc, exp_len);
        end
        for (int i = 0; i < exp_len; i++) begin
            ref_mem[i]   = stream[i];
            ref_known[i] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; length = '0; in_valid = 1'b0; in_byte = '0; addr = '0;
        tick();
        tick();
        n_cmp++;
        if ({in_ready, busy, done, cpu_rst} !== 4'b0001) begin
            n_bad++;
            $display("[TB] FAIL reset_state actual=%b required=0001", {in_ready, busy, done, cpu_rst});
        end
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({in_ready, busy, done, cpu_rst} !== 4'b0001) begin
            n_bad++;
            $display("[TB] FAIL idle_hold actual=%b required=0001", {in_ready, busy, done, cpu_rst});
        end
    endtask

    task automatic test_basic_load();
        stream[0] = 8'h13; stream[1] = 8'h05; stream[2] = 8'h10; stream[3] = 8'h00;
        run_load(4, 0, 1'b0);
        addr = 32'h0;
        #1;
        n_cmp++;
        if (instr !== 32'h0010_0513) begin
            n_bad++;
            $display("[TB] FAIL basic_word actual=%08h required=00100513", instr);
        end
        repeat (3) tick();
        n_cmp++;
        if (done !== 1'b1 || cpu_rst !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL done_sticky actual=%b%b required=10", done, cpu_rst);
        end
    endtask

    task automatic test_wrap_read();
        for (int i = 0; i < 256; i++) stream[i] = 8'(i);
        run_load(256, 0, 1'b0);
        addr = 32'h0000_00FE;
        #1;
        n_cmp++;
        if (instr !== 32'h0100_FFFE) begin
            n_bad++;
            $display("[TB] FAIL wrap_fe actual=%08h required=0100fffe", instr);
        end
        addr = 32'h0000_01FC;
        #1;
        n_cmp++;
        if (instr !== 32'hFFFE_FDFC) begin
            n_bad++;
            $display("[TB] FAIL alias_1fc actual=%08h required=fffefdfc", instr);
        end
    endtask

    task automatic test_throttled();
        for (int i = 0; i < 8; i++) stream[i] = 8'($urandom());
        run_load(8, 1, 1'b0);
        addr = 32'h4;
        #1;
        n_cmp++;
        if (instr !== {stream[7], stream[6], stream[5], stream[4]}) begin
            n_bad++;
            $display("[TB] FAIL throttle_word4 actual=%08h required=%08h",
                     instr, {stream[7], stream[6], stream[5], stream[4]});
        end
        for (int a = 0; a < 256; a++) begin
            if (word_known(a)) begin
                addr = ($urandom() & 32'hFFFF_FF00) | 32'(a);
                #1;
                n_cmp++;
                if (instr !== model_word(a)) begin
                    n_bad++;
                    $display("[TB] FAIL throttle_mem addr=%02h actual=%08h required=%08h",
                             a, instr, model_word(a));
                end
            end
        end
    endtask

    task automatic test_zero_oversize();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        start    = 1'b1;
        length   = '0;
        in_valid = 1'b1;
        in_byte  = ~ref_mem[0];
        addr     = 32'h0;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({in_ready, busy, done, cpu_rst} !== 4'b0010) begin
            n_bad++;
            $display("[TB] FAIL zero_len_done actual=%b required=0010", {in_ready, busy, done, cpu_rst});
        end
        n_cmp++;
        if (instr !== model_word(0)) begin
            n_bad++;
            $display("[TB] FAIL zero_len_nowrite actual=%08h required=%08h", instr, model_word(0));
        end
        for (int i = 0; i < 300; i++) stream[i] = 8'($urandom());
        run_load(300, 2, 1'b0);
        in_valid = 1'b1;
        in_byte  = ~stream[0];
        repeat (2) tick();
        in_valid = 1'b0;
        for (int a = 0; a < 256; a++) begin
            addr = ($urandom() & 32'hFFFF_FF00) | 32'(a);
            #1;
            n_cmp++;
            if (instr !== model_word(a)) begin
                n_bad++;
                $display("[TB] FAIL oversize_mem addr=%02h actual=%08h required=%08h",
                         a, instr, model_word(a));
            end
        end
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 8; i++) stream[i] = 8'($urandom());
        start  = 1'b1;
        length = 9'd8;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_byte  = stream[k];
            tick();
        end
        rst      = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_byte  = ~ref_mem[3];
        tick();
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({in_ready, busy, done, cpu_rst} !== 4'b0001) begin
            n_bad++;
            $display("[TB] FAIL mid_reset_state actual=%b required=0001", {in_ready, busy, done, cpu_rst});
        end
        tick();
        n_cmp++;
        if ({in_ready, busy, done, cpu_rst} !== 4'b0001) begin
            n_bad++;
            $display("[TB] FAIL mid_reset_idle actual=%b required=0001", {in_ready, busy, done, cpu_rst});
        end
        for (int k = 0; k < 3; k++) begin
            ref_mem[k]   = stream[k];
            ref_known[k] = 1'b1;
        end
        for (int a = 0; a < 8; a++) begin
            addr = 32'(a);
            #1;
            n_cmp++;
            if (instr !== model_word(a)) begin
                n_bad++;
                $display("[TB] FAIL mid_reset_mem addr=%02h actual=%08h required=%08h",
                         a, instr, model_word(a));
            end
        end
    endtask

    task automatic test_reload();
        for (int i = 0; i < 5; i++) stream[i] = 8'($urandom());
        run_load(5, 0, 1'b0);
        for (int i = 0; i < 6; i++) stream[i] = 8'($urandom());
        run_load(6, 2, 1'b1);
        for (int a = 0; a < 12; a++) begin
            addr = 32'(a);
            #1;
            n_cmp++;
            if (instr !== model_word(a)) begin
                n_bad++;
                $display("[TB] FAIL reload_mem addr=%02h actual=%08h required=%08h",
                         a, instr, model_word(a));
            end
        end
    endtask

    task automatic test_random_loads();
        int len;
        for (int n = 0; n < 4; n++) begin
            len = int'($urandom_range(1, 60));
            for (int i = 0; i < len; i++) stream[i] = 8'($urandom());
            run_load(len, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            for (int a = 0; a < len + 4; a++) begin
                addr = ($urandom() & 32'hFFFF_FF00) | 32'(a);
                #1;
                n_cmp++;
                if (instr !== model_word(a)) begin
                    n_bad++;
                    $display("[TB] FAIL random_mem load=%0d addr=%02h actual=%08h required=%08h",
                             n, a, instr, model_word(a));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 8'h00;
            ref_known[i] = 1'b0;
        end
        test_reset();
        test_basic_load();
        test_wrap_read();
        test_throttled();
        test_zero_oversize();
        test_reset_mid_load();
        test_reload();
        test_random_loads();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Writer side of the byte-addressed instruction memory. It accepts a program as a byte stream over a valid/ready handshake and writes it little-endian into a 256-byte instruction RAM. It holds the CPU in reset while loading. The combinational 32-bit fetch port is unchanged, so the fetch stage reads loaded words exactly as it reads the ROM image.

## Interface
- ADDRESS_WIDTH, 32, fetch address width
- DATA_WIDTH, 32, instruction width (4 bytes)
- MEM_ADDR_BITS, 8, byte-address bits actually decoded (256 bytes)
- BYTE_WIDTH, 8, stream and storage granularity

Clock and reset: one clock; reset is synchronous and active-high.

- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load
- length  input  MEM_ADDR_BITS+1  number of bytes to load, sampled on accepted start
- in_valid  input  1  in_byte holds a valid byte
- in_byte  input  BYTE_WIDTH  program byte, in ascending address order
- in_ready  output  1  loader accepts a byte this cycle
- busy  output  1  load in progress
- done  output  1  last load completed; stays high until the next start or rst
- cpu_rst  output  1  core reset request; high except in DONE
- addr  input  ADDRESS_WIDTH  fetch byte address; only addr[7:0] decoded
- instr  output  DATA_WIDTH  {mem[a+3], mem[a+2], mem[a+1], mem[a]}, a = addr[7:0]

## Operation
States are IDLE, LOAD and DONE.

- **Reset:** state=IDLE, wr_ptr=0, count latch=0, in_ready=0, busy=0, done=0, cpu_rst=1. RAM contents are not cleared.
- **IDLE:** start → latch length, wr_ptr=0.
  - length==0 → DONE.
  - Otherwise → LOAD.
- **LOAD:** in_ready=1, busy=1, cpu_rst=1. On in_valid&&in_ready:
  - mem[wr_ptr] ← in_byte, and wr_ptr increments.
  - If this byte is byte number length, → DONE.
  - start is ignored in LOAD.
- **DONE:** done=1, cpu_rst=0, in_ready=0. start → same behaviour as from IDLE (reload), with done and cpu_rst returning to 0 and 1.
- **length clamping:** length>256 is clamped to 256. wr_ptr is MEM_ADDR_BITS wide and never wraps within a load.
- **Fetch port:** purely combinational from RAM. Each of the four byte indices is computed mod 256, so a=0xFE reads bytes FE, FF, 00, 01.
- **Ignored inputs:** in_byte is ignored when in_valid=0. in_valid is ignored outside LOAD.
- **Reset mid-load:** → IDLE. Bytes already written stay written; the partial load is not reported as done.

## Timing
- A byte is written at the rising edge where in_valid&&in_ready. It is visible on instr from that edge onward.
- Same-cycle fetch of the byte being written returns the old value.
- Throughput is one byte per cycle; in_ready does not depend on in_valid (no combinational path).
- **Entering LOAD:** in_ready, busy and cpu_rst take their LOAD values in the cycle after start is accepted.
- **Load complete:** done=1 and cpu_rst=0 in the cycle after the final byte's accepting edge.
- **Zero-length load:** start with length=0 produces done=1 one cycle after start.
- **rst precedence:** rst overrides start and handshakes in the same cycle.

## Structure
- The shared package `loader_pkg` holds:
  - the state enum (IDLE, LOAD, DONE);
  - MEM_BYTES=256;
  - BYTE_WIDTH.
- The sub-module `instr_ram` contains:
  - a 256×8 array;
  - one synchronous byte write port (we, waddr, wdata);
  - one combinational 4-byte little-endian read port with per-byte mod-256 wrap.
- `prog_loader` holds the FSM, the pointer and the length latch, and instantiates `instr_ram`.

## Test plan
- **Basic load:** rst, then start with length=4, then bytes 0x13,0x05,0x10,0x00 with continuous valid, then addr=0.
  - Required: instr=0x00100513.
  - Required: done rises one cycle after the 4th accept.
  - Required: cpu_rst falls in that same cycle.
- **Throttled stream:** length=8 with in_valid toggled 1,0,0,1,…
  - Required: exactly 8 bytes are written, in order.
  - Required: bytes offered while in_valid=0 are not written.
  - Required: addr=4 returns the second word correctly.
- **Wrap read:** load 256 bytes with value = index, then addr=0xFE.
  - Required: instr=0x0100FFFE.
  - Required: addr=0x1FC aliases to 0xFC and gives 0xFFFEFDFC.
- **Zero and oversize length:**
  - length=0 → done one cycle after start, no writes.
  - length=300 → exactly 256 bytes accepted before done.
- **Reset mid-load:** rst asserted after 3 of 8 bytes.
  - Required: IDLE, done=0, cpu_rst=1, in_ready=0.
  - Required: bytes 0..2 retain the new data.
- **Reload from DONE:** start in DONE.
  - Required: cpu_rst=1 and done=0 on the next cycle.
  - Required: the new bytes overwrite from address 0.
  - Required: start asserted during LOAD has no effect.
